video_timing_gen: RTL and testbench

Parametrised raster timing generator. It produces horizontal/vertical sync, blanking, pixel coordinates, line/frame strobes and a frame counter for the video pipeline. The pixel rate is set by a clock-enable, so the block runs at pixel clock or any integer divisor of the system clock. A synchronous `restart` lets an external reference genlock the raster. All outputs are registered and mutually aligned, so downstream pattern logic (colour-bar generators, overlays) can use them without realignment.

---
 rtl/video_timing_pkg.sv | 51 +++++
 rtl/video_timing_gen_if.sv | 37 +++
 rtl/timing_axis.sv | 59 +++++
 rtl/video_timing_gen.sv | 147 ++++++++++++++
 tb/tb_video_timing_gen.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_pkg
// Description : Phase encoding, next-phase helper and default raster timing
//               for the video timing generator.
// Revision    : 1.0 - initial release
// ============================================================================
package video_timing_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } phase_t;

    localparam int unsigned c_h_display = 256;
    localparam int unsigned c_h_front   = 7;
    localparam int unsigned c_h_sync    = 23;
    localparam int unsigned c_h_back    = 23;
    localparam int unsigned c_v_display = 240;
    localparam int unsigned c_v_bottom  = 14;
    localparam int unsigned c_v_sync    = 3;
    localparam int unsigned c_v_top     = 5;

    // Phase for the count the axis moves to; zero-length porches are skipped
    // so the FSM never spends a pixel in an empty segment.
    function automatic phase_t next_phase(
        input phase_t      cur,
        input int unsigned nxt,
        input logic        wrap,
        input int unsigned a_len,
        input int unsigned f_len,
        input int unsigned s_len,
        input int unsigned b_len
    );
        phase_t p;
        p = cur;
        case (cur)
            ACTIVE: if (nxt == a_len)               p = (f_len == 0) ? SYNC : FRONT;
            FRONT:  if (nxt == a_len + f_len)       p = SYNC;
            SYNC:   if ((b_len == 0) ? wrap : (nxt == a_len + f_len + s_len))
                                                    p = (b_len == 0) ? ACTIVE : BACK;
            BACK:   if (wrap)                       p = ACTIVE;
            default:                                p = ACTIVE;
        endcase
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen_if
// Description : Pixel-enable/restart inputs and registered raster outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface video_timing_gen_if #(
    parameter int unsigned H_BITS = 9,
    parameter int unsigned V_BITS = 9,
    parameter int unsigned F_BITS = 8
);
    logic              ce;
    logic              restart;
    logic              hsync;
    logic              vsync;
    logic              display_on;
    logic              hblank;
    logic              vblank;
    logic [H_BITS-1:0] hpos;
    logic [V_BITS-1:0] vpos;
    logic              line_start;
    logic              frame_start;
    logic [F_BITS-1:0] frame_count;

    modport master (
        input  ce, restart,
        output hsync, vsync, display_on, hblank, vblank,
               hpos, vpos, line_start, frame_start, frame_count
    );

    modport slave (
        output ce, restart,
        input  hsync, vsync, display_on, hblank, vblank,
               hpos, vpos, line_start, frame_start, frame_count
    );
endinterface
`default_nettype wire

// File: rtl/timing_axis.sv
`default_nettype none
// ============================================================================
// Module      : timing_axis
// Description : One raster axis: wrapping counter plus ACTIVE/FRONT/SYNC/BACK
//               phase FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module timing_axis
    import video_timing_pkg::*;
#(
    parameter int unsigned WIDTH      = 9,
    parameter int unsigned ACTIVE_LEN = 256,
    parameter int unsigned FRONT_LEN  = 7,
    parameter int unsigned SYNC_LEN   = 23,
    parameter int unsigned BACK_LEN   = 23,
    parameter bit          SYNC_NEG   = 1'b0
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             advance,
    input  wire logic             restart,
    output logic      [WIDTH-1:0] count,
    output phase_t                phase,
    output logic                  wrap,
    output logic                  sync
);

    localparam int unsigned c_total = ACTIVE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN;
    localparam int unsigned c_max   = c_total - 1;

    logic [WIDTH-1:0] r_count;
    phase_t           r_phase;
    logic             w_wrap;
    logic [WIDTH-1:0] w_next;

    assign w_wrap = (r_count == WIDTH'(c_max));
    assign w_next = w_wrap ? '0 : r_count + WIDTH'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_phase <= ACTIVE;
        end else if (restart) begin
            r_count <= '0;
            r_phase <= ACTIVE;
        end else if (advance) begin
            r_count <= w_next;
            r_phase <= next_phase(r_phase, 32'(w_next), w_wrap,
                                  ACTIVE_LEN, FRONT_LEN, SYNC_LEN, BACK_LEN);
        end
    end

    assign count = r_count;
    assign phase = r_phase;
    assign wrap  = w_wrap;
    assign sync  = (r_phase == SYNC) ^ SYNC_NEG;

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen
// Description : Parametrised raster timing generator with registered, aligned
//               sync/blank/position/strobe outputs and a frame counter.
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_DISPLAY  = c_h_display,
    parameter int unsigned H_FRONT    = c_h_front,
    parameter int unsigned H_SYNC     = c_h_sync,
    parameter int unsigned H_BACK     = c_h_back,
    parameter bit          H_SYNC_NEG = 1'b0,
    parameter int unsigned V_DISPLAY  = c_v_display,
    parameter int unsigned V_BOTTOM   = c_v_bottom,
    parameter int unsigned V_SYNC     = c_v_sync,
    parameter int unsigned V_TOP      = c_v_top,
    parameter bit          V_SYNC_NEG = 1'b0,
    parameter int unsigned H_BITS     = 9,
    parameter int unsigned V_BITS     = 9,
    parameter int unsigned F_BITS     = 8
) (
    input wire logic         clk,
    input wire logic         reset_n,
    video_timing_gen_if.master vif
);

    localparam int unsigned c_h_max = H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1;
    localparam int unsigned c_v_max = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1;

    generate
        if (H_SYNC == 0 || V_SYNC == 0 || H_DISPLAY == 0 || V_DISPLAY == 0 ||
            (c_h_max >> H_BITS) != 0 || (c_v_max >> V_BITS) != 0) begin : g_bad_timing
            $error("video_timing_gen: invalid timing parameters");
        end
    endgenerate

    logic [H_BITS-1:0] w_h_cnt;
    logic [V_BITS-1:0] w_v_cnt;
    phase_t            w_h_phase;
    phase_t            w_v_phase;
    logic              w_h_wrap;
    logic              w_v_wrap;
    logic              w_h_sync;
    logic              w_v_sync;
    logic              w_restart;

    assign w_restart = vif.ce & vif.restart;

    timing_axis #(
        .WIDTH      (H_BITS),
        .ACTIVE_LEN (H_DISPLAY),
        .FRONT_LEN  (H_FRONT),
        .SYNC_LEN   (H_SYNC),
        .BACK_LEN   (H_BACK),
        .SYNC_NEG   (H_SYNC_NEG)
    ) u_h_axis (
        .clk     (clk),
        .reset_n (reset_n),
        .advance (vif.ce),
        .restart (w_restart),
        .count   (w_h_cnt),
        .phase   (w_h_phase),
        .wrap    (w_h_wrap),
        .sync    (w_h_sync)
    );

    timing_axis #(
        .WIDTH      (V_BITS),
        .ACTIVE_LEN (V_DISPLAY),
        .FRONT_LEN  (V_BOTTOM),
        .SYNC_LEN   (V_SYNC),
        .BACK_LEN   (V_TOP),
        .SYNC_NEG   (V_SYNC_NEG)
    ) u_v_axis (
        .clk     (clk),
        .reset_n (reset_n),
        .advance (vif.ce & w_h_wrap),
        .restart (w_restart),
        .count   (w_v_cnt),
        .phase   (w_v_phase),
        .wrap    (w_v_wrap),
        .sync    (w_v_sync)
    );

    logic [H_BITS-1:0] r_hpos;
    logic [V_BITS-1:0] r_vpos;
    logic              r_hsync;
    logic              r_vsync;
    logic              r_display_on;
    logic              r_hblank;
    logic              r_vblank;
    logic              r_line_start;
    logic              r_frame_start;
    logic [F_BITS-1:0] r_frame_count;
    logic              r_wrap_pend;

    // r_wrap_pend remembers a natural (H_MAX,V_MAX) wrap so the count bumps
    // on the same ce that registers (0,0), aligned with frame_start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hpos        <= '0;
            r_vpos        <= '0;
            r_hsync       <= H_SYNC_NEG;
            r_vsync       <= V_SYNC_NEG;
            r_display_on  <= 1'b0;
            r_hblank      <= 1'b1;
            r_vblank      <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
            r_wrap_pend   <= 1'b0;
        end else if (vif.ce) begin
            r_hpos        <= w_h_cnt;
            r_vpos        <= w_v_cnt;
            r_hsync       <= w_h_sync;
            r_vsync       <= w_v_sync;
            r_display_on  <= (w_h_phase == ACTIVE) && (w_v_phase == ACTIVE);
            r_hblank      <= (w_h_phase != ACTIVE);
            r_vblank      <= (w_v_phase != ACTIVE);
            r_line_start  <= (w_h_cnt == '0);
            r_frame_start <= (w_h_cnt == '0) && (w_v_cnt == '0);
            r_wrap_pend   <= w_h_wrap & w_v_wrap & ~vif.restart;
            if (r_wrap_pend) begin
                r_frame_count <= r_frame_count + F_BITS'(1);
            end
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign vif.hpos        = r_hpos;
    assign vif.vpos        = r_vpos;
    assign vif.hsync       = r_hsync;
    assign vif.vsync       = r_vsync;
    assign vif.display_on  = r_display_on;
    assign vif.hblank      = r_hblank;
    assign vif.vblank      = r_vblank;
    assign vif.line_start  = r_line_start;
    assign vif.frame_start = r_frame_start;
    assign vif.frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_timing_gen
// Description : Scoreboard bench for video_timing_gen on three small rasters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

    typedef struct packed {
        logic [8:0] hpos;
        logic [8:0] vpos;
        logic       hsync;
        logic       vsync;
        logic       display_on;
        logic       hblank;
        logic       vblank;
        logic       line_start;
        logic       frame_start;
        logic [7:0] fc;
    } exp_t;

    typedef struct {
        int hd, hf, hs, hb, vd, vb, vs, vt;
        bit hneg, vneg;
        int fbits;
    } cfg_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic ce      [3] = '{1'b0, 1'b0, 1'b0};
    logic restart [3] = '{1'b0, 1'b0, 1'b0};
    logic rst_n   [3] = '{1'b0, 1'b0, 1'b0};

    video_timing_gen_if #(.H_BITS(9), .V_BITS(9), .F_BITS(8)) if0 ();
    video_timing_gen_if #(.H_BITS(9), .V_BITS(9), .F_BITS(8)) if1 ();
    video_timing_gen_if #(.H_BITS(9), .V_BITS(9), .F_BITS(2)) if2 ();

    assign if0.ce = ce[0];  assign if0.restart = restart[0];
    assign if1.ce = ce[1];  assign if1.restart = restart[1];
    assign if2.ce = ce[2];  assign if2.restart = restart[2];

    video_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1), .H_SYNC_NEG(1'b0),
        .V_DISPLAY(4), .V_BOTTOM(1), .V_SYNC(2), .V_TOP(1), .V_SYNC_NEG(1'b0),
        .H_BITS(9), .V_BITS(9), .F_BITS(8)
    ) dut0 (.clk(clk), .reset_n(rst_n[0]), .vif(if0));

    video_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(0), .H_SYNC(3), .H_BACK(1), .H_SYNC_NEG(1'b0),
        .V_DISPLAY(4), .V_BOTTOM(1), .V_SYNC(2), .V_TOP(0), .V_SYNC_NEG(1'b0),
        .H_BITS(9), .V_BITS(9), .F_BITS(8)
    ) dut1 (.clk(clk), .reset_n(rst_n[1]), .vif(if1));

    video_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1), .H_SYNC_NEG(1'b1),
        .V_DISPLAY(4), .V_BOTTOM(1), .V_SYNC(2), .V_TOP(1), .V_SYNC_NEG(1'b1),
        .H_BITS(9), .V_BITS(9), .F_BITS(2)
    ) dut2 (.clk(clk), .reset_n(rst_n[2]), .vif(if2));

    exp_t act [3];
    assign act[0] = {if0.hpos, if0.vpos, if0.hsync, if0.vsync, if0.display_on, if0.hblank,
                     if0.vblank, if0.line_start, if0.frame_start, if0.frame_count};
    assign act[1] = {if1.hpos, if1.vpos, if1.hsync, if1.vsync, if1.display_on, if1.hblank,
                     if1.vblank, if1.line_start, if1.frame_start, if1.frame_count};
    assign act[2] = {if2.hpos, if2.vpos, if2.hsync, if2.vsync, if2.display_on, if2.hblank,
                     if2.vblank, if2.line_start, if2.frame_start, 6'd0, if2.frame_count};

    int total = 0;
    int bad   = 0;

    exp_t q0[$], q1[$], q2[$];
    cfg_t cfg [3];
    int   mh [3], mv [3], mfc [3];
    bit   mpend [3];

    function automatic string fmt(exp_t e);
        return $sformatf("h=%0d v=%0d hs=%b vs=%b de=%b hb=%b vb=%b ls=%b fs=%b fc=%0d",
                         e.hpos, e.vpos, e.hsync, e.vsync, e.display_on, e.hblank,
                         e.vblank, e.line_start, e.frame_start, e.fc);
    endfunction

    task automatic check(input string name, input exp_t got, input exp_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %s required %s", name, fmt(got), fmt(want));
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    function automatic exp_t reset_rec(int i);
        exp_t e;
        e = '0;
        e.hsync  = cfg[i].hneg;
        e.vsync  = cfg[i].vneg;
        e.hblank = 1'b1;
        e.vblank = 1'b1;
        return e;
    endfunction

    task automatic push(input int i, input exp_t e);
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // One pixel slot for DUT i, driven ahead of the next rising edge.
    task automatic tick(input int i, input bit en, input bit rs);
        exp_t e;
        int   ht, vt, hs0, vs0;
        @(negedge clk);
        ce[i]      = en;
        restart[i] = en & rs;
        if (en) begin
            ht  = cfg[i].hd + cfg[i].hf + cfg[i].hs + cfg[i].hb;
            vt  = cfg[i].vd + cfg[i].vb + cfg[i].vs + cfg[i].vt;
            hs0 = cfg[i].hd + cfg[i].hf;
            vs0 = cfg[i].vd + cfg[i].vb;
            if (mpend[i]) mfc[i] = (mfc[i] + 1) % (1 << cfg[i].fbits);
            e             = '0;
            e.hpos        = 9'(mh[i]);
            e.vpos        = 9'(mv[i]);
            e.hsync       = ((mh[i] >= hs0) && (mh[i] < hs0 + cfg[i].hs)) ^ cfg[i].hneg;
            e.vsync       = ((mv[i] >= vs0) && (mv[i] < vs0 + cfg[i].vs)) ^ cfg[i].vneg;
            e.hblank      = (mh[i] >= cfg[i].hd);
            e.vblank      = (mv[i] >= cfg[i].vd);
            e.display_on  = !e.hblank && !e.vblank;
            e.line_start  = (mh[i] == 0);
            e.frame_start = (mh[i] == 0) && (mv[i] == 0);
            e.fc          = 8'(mfc[i]);
            push(i, e);
            if (rs) begin
                mh[i] = 0; mv[i] = 0; mpend[i] = 1'b0;
            end else begin
                mpend[i] = (mh[i] == ht - 1) && (mv[i] == vt - 1);
                if (mh[i] == ht - 1) begin
                    mh[i] = 0;
                    mv[i] = (mv[i] == vt - 1) ? 0 : mv[i] + 1;
                end else begin
                    mh[i]++;
                end
            end
        end
    endtask

    // Monitor: pops the scoreboard on every ce edge, otherwise demands
    // frozen levels and silent strobes.
    exp_t prev [3];
    exp_t mexp;
    bit   ces [3];
    bit   rss [3];
    int   cyc = 0;
    int   last_fs0 = -1;
    int   gap0 = 0;
    int   fcq[$];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            ces[i] = ce[i];
            rss[i] = rst_n[i];
        end
        cyc++;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (!rss[i] || !rst_n[i]) begin
                prev[i] = act[i];
                continue;
            end
            if (ces[i]) begin
                if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0) ||
                    (i == 2 && q2.size() == 0)) begin
                    total++;
                    bad++;
                    $display("FAIL sb%0d: output on ce with empty queue, got %s", i, fmt(act[i]));
                end else begin
                    case (i)
                        0: mexp = q0.pop_front();
                        1: mexp = q1.pop_front();
                        default: mexp = q2.pop_front();
                    endcase
                    check($sformatf("sb%0d", i), act[i], mexp);
                end
            end else begin
                mexp = prev[i];
                mexp.line_start  = 1'b0;
                mexp.frame_start = 1'b0;
                check($sformatf("hold%0d", i), act[i], mexp);
            end
            prev[i] = act[i];
            if (act[i].frame_start) begin
                if (i == 0) begin
                    if (last_fs0 >= 0) gap0 = cyc - last_fs0;
                    last_fs0 = cyc;
                end
                if (i == 2) fcq.push_back(int'(act[2].fc));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        exp_t hand;
        int   saved_fc;
        int   n;
        int   fc_want [5] = '{0, 1, 2, 3, 0};

        cfg[0] = '{8, 2, 3, 1, 4, 1, 2, 1, 1'b0, 1'b0, 8};
        cfg[1] = '{8, 0, 3, 1, 4, 1, 2, 0, 1'b0, 1'b0, 8};
        cfg[2] = '{8, 2, 3, 1, 4, 1, 2, 1, 1'b1, 1'b1, 2};
        for (int i = 0; i < 3; i++) begin
            mh[i] = 0; mv[i] = 0; mfc[i] = 0; mpend[i] = 1'b0;
        end

        repeat (3) @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++) check($sformatf("reset%0d", i), act[i], reset_rec(i));
        @(negedge clk);
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
        repeat (2) @(negedge clk);

        // ce every clk: three frame starts, 112-clk period
        repeat (2 * 112 + 4) tick(0, 1'b1, 1'b0);
        tick(0, 1'b0, 1'b0);
        @(posedge clk); #2;
        check_int("fs_period_ce1", gap0, 112);

        // ce every third clk
        repeat (240) begin
            tick(0, 1'b1, 1'b0);
            tick(0, 1'b0, 1'b0);
            tick(0, 1'b0, 1'b0);
        end
        @(posedge clk); #2;
        check_int("fs_period_ce3", gap0, 336);

        // restart at (5,2)
        n = 0;
        while (!(mh[0] == 5 && mv[0] == 2) && n < 200) begin
            tick(0, 1'b1, 1'b0);
            n++;
        end
        check_int("reach_5_2", n < 200 ? 1 : 0, 1);
        saved_fc = mfc[0];
        tick(0, 1'b1, 1'b1);
        tick(0, 1'b1, 1'b0);
        @(posedge clk); #2;
        hand             = '0;
        hand.display_on  = 1'b1;
        hand.line_start  = 1'b1;
        hand.frame_start = 1'b1;
        hand.fc          = 8'(saved_fc);
        check("restart_origin", act[0], hand);
        repeat (5) tick(0, 1'b1, 1'b0);
        tick(0, 1'b0, 1'b0);

        // zero front porch / zero top border
        repeat (2 * 84 + 3) tick(1, 1'b1, 1'b0);
        tick(1, 1'b0, 1'b0);

        // 2-bit frame counter over four full frames, active-low syncs
        repeat (4 * 112 + 1) tick(2, 1'b1, 1'b0);
        tick(2, 1'b0, 1'b0);
        @(posedge clk); #2;
        check_int("fc_seq_len", fcq.size(), 5);
        for (int k = 0; k < 5 && k < fcq.size(); k++)
            check_int($sformatf("fc_seq%0d", k), fcq[k], fc_want[k]);

        // async reset while both syncs are active
        n = 0;
        while (!(mh[2] == 11 && mv[2] == 5) && n < 200) begin
            tick(2, 1'b1, 1'b0);
            n++;
        end
        tick(2, 1'b1, 1'b0);
        @(posedge clk); #3;
        check_int("in_sync_h", int'(if2.hsync), 0);
        check_int("in_sync_v", int'(if2.vsync), 0);
        rst_n[2] = 1'b0;
        #1;
        check("async_reset", act[2], reset_rec(2));
        mh[2] = 0; mv[2] = 0; mfc[2] = 0; mpend[2] = 1'b0;
        tick(2, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n[2] = 1'b1;
        repeat (20) tick(2, 1'b1, 1'b0);
        tick(2, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        check_int("sb_drain", q0.size() + q1.size() + q2.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
